// File: rtl/ber_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ber_checker_pkg
// Description : Shared definitions for the BER checker: FSM state encoding,
//               PRBS9 generator constants/helper and default geometry.
// Revision    : 1.0  initial release
// ============================================================================
package ber_checker_pkg;

    // Checker state; explicit 1-bit encoding.
    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

    localparam int unsigned c_DEFAULT_DEPTH  = 512;
    localparam int unsigned c_DEFAULT_WINDOW = 511;

    // PRBS9: x^9 + x^5 + 1, Fibonacci form, output taken from the MSB.
    localparam int unsigned c_PRBS9_TAP_HI = 9;
    localparam int unsigned c_PRBS9_TAP_LO = 5;
    localparam logic [8:0]  c_PRBS9_SEED   = 9'h1FF;

    function automatic logic [8:0] prbs9_next(input logic [8:0] state);
        return {state[7:0], state[c_PRBS9_TAP_HI-1] ^ state[c_PRBS9_TAP_LO-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ber_ref_history.sv
`default_nettype none
// ============================================================================
// Module      : ber_ref_history
// Description : Reference-bit history. hist[0] is the live input bit,
//               hist[k] is the bit from k shifts ago; only hist[1..DEPTH-1]
//               are stored. A combinational mux returns hist[i_delay].
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_shift         - advance the history by one bit
//               i_ref_bit       - current reference bit (hist[0])
//               i_delay         - history tap to read
//               o_hist_bit      - hist[i_delay]
// Revision    : 1.0  initial release
// ============================================================================
module ber_ref_history
    import ber_checker_pkg::*;
#(
    parameter int unsigned DEPTH = c_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_shift,
    input  logic                     i_ref_bit,
    input  logic [$clog2(DEPTH)-1:0] i_delay,
    output logic                     o_hist_bit
);

    logic [DEPTH-1:1] r_sr;
    logic [DEPTH-1:0] w_hist;

    assign w_hist = {r_sr, i_ref_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= w_hist[DEPTH-2:0];
        end
    end

    assign o_hist_bit = w_hist[i_delay];

endmodule
`default_nettype wire

// File: rtl/ber_checker.sv
`default_nettype none
// ============================================================================
// Module      : ber_checker
// Description : Bit-error-rate checker. Sweeps every candidate latency over
//               a window of reference history, locks to the delay with the
//               fewest errors (earliest on ties) and then accumulates
//               saturating bit/error counts.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               enable          - global enable; strobes ignored when low
//               i_valid         - symbol strobe (qualified with enable)
//               i_ref_bit       - transmitted PRBS bit
//               i_rx_bit        - received hard decision
//               i_clear         - restart search/counters (history kept)
//               o_locked        - high while locked
//               o_delay         - selected latency in symbols
//               o_bit_count     - bits compared while locked
//               o_err_count     - errors counted while locked
// Config      : BER_CHECKER_RELOCK_EN - when defined, a locked window with
//               more than RELOCK_THR errors restarts the search.
// Revision    : 1.0  initial release
// ============================================================================
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int unsigned DEPTH      = c_DEFAULT_DEPTH,
    parameter int unsigned WINDOW     = c_DEFAULT_WINDOW,
    parameter int unsigned CNT_W      = 64,
    parameter int unsigned RELOCK_THR = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     i_valid,
    input  logic                     i_ref_bit,
    input  logic                     i_rx_bit,
    input  logic                     i_clear,
    output logic                     o_locked,
    output logic [$clog2(DEPTH)-1:0] o_delay,
    output logic [CNT_W-1:0]         o_bit_count,
    output logic [CNT_W-1:0]         o_err_count
);

    localparam int unsigned c_DW = $clog2(DEPTH);
    localparam int unsigned c_WW = $clog2(WINDOW + 1);

`ifdef BER_CHECKER_RELOCK_EN
    localparam bit c_RELOCK_EN = 1'b1;
`else
    localparam bit c_RELOCK_EN = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_DW-1:0]   r_delay;
    logic [c_DW-1:0]   r_best;
    logic [c_WW-1:0]   r_win_cnt;
    logic [c_WW-1:0]   r_win_err;
    logic [c_WW-1:0]   r_min_err;
    logic [CNT_W-1:0]  r_bit_count;
    logic [CNT_W-1:0]  r_err_count;

    logic              w_strobe;
    logic              w_hist_bit;
    logic              w_e;
    logic [c_WW-1:0]   w_win_total;
    logic              w_win_last;
    logic              w_delay_last;
    logic              w_better;
    logic              w_relock_hit;

    assign w_strobe = enable && i_valid;

    // A strobe coinciding with i_clear is dropped entirely, history included.
    ber_ref_history #(
        .DEPTH      (DEPTH)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .i_shift    (w_strobe && !i_clear),
        .i_ref_bit  (i_ref_bit),
        .i_delay    (r_delay),
        .o_hist_bit (w_hist_bit)
    );

    assign w_e          = i_rx_bit ^ w_hist_bit;
    // Window total including the current strobe's error bit.
    assign w_win_total  = r_win_err + c_WW'(w_e);
    assign w_win_last   = (r_win_cnt == c_WW'(WINDOW - 1));
    assign w_delay_last = (r_delay == c_DW'(DEPTH - 1));
    assign w_better     = (w_win_total < r_min_err);
    assign w_relock_hit = (32'(w_win_total) > RELOCK_THR);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_strobe) begin
            case (r_state)
                SEARCH: begin
                    if (w_win_last && w_delay_last) begin
                        w_state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (c_RELOCK_EN && w_win_last && w_relock_hit) begin
                        w_state_nxt = SEARCH;
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_locked    = (r_state == LOCK);
        o_delay     = r_delay;
        o_bit_count = r_bit_count;
        o_err_count = r_err_count;
    end

    // ---------------- Search / lock datapath ----------------
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_delay     <= '0;
            r_best      <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_min_err   <= '1;
            r_bit_count <= '0;
            r_err_count <= '0;
        end else if (w_strobe) begin
            if (r_state == SEARCH) begin
                if (w_win_last) begin
                    r_win_cnt <= '0;
                    r_win_err <= '0;
                    if (w_better) begin
                        r_min_err <= w_win_total;
                        r_best    <= r_delay;
                    end
                    // The last window's result may itself be the winner, so
                    // the lock delay is resolved against this window too.
                    if (w_delay_last) begin
                        r_delay <= w_better ? r_delay : r_best;
                    end else begin
                        r_delay <= r_delay + 1'b1;
                    end
                end else begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_win_err <= w_win_total;
                end
            end else begin
                if (r_bit_count != {CNT_W{1'b1}}) begin
                    r_bit_count <= r_bit_count + 1'b1;
                end
                if (w_e && (r_err_count != {CNT_W{1'b1}})) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (c_RELOCK_EN) begin
                    if (w_win_last) begin
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                        if (w_relock_hit) begin
                            r_delay   <= '0;
                            r_best    <= '0;
                            r_min_err <= '1;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                        r_win_err <= w_win_total;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ber_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ber_checker
// Description : Directed self-checking bench for ber_checker (DEPTH=64,
//               WINDOW=63, RELOCK_THR=10). Feeds PRBS9 reference bits and a
//               delayed/corrupted copy as the received stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ber_checker;

    localparam int unsigned c_DEPTH  = 64;
    localparam int unsigned c_WINDOW = 63;
    localparam int          c_SEARCH = 64 * 63;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        i_valid;
    logic        i_ref_bit;
    logic        i_rx_bit;
    logic        i_clear;
    logic        o_locked;
    logic [5:0]  o_delay;
    logic [31:0] o_bit_count;
    logic [31:0] o_err_count;

    int          n_cmp;
    int          n_fail;
    logic [8:0]  r_prbs;
    logic        tx_hist [0:63];
    int          lat;

    ber_checker #(
        .DEPTH      (c_DEPTH),
        .WINDOW     (c_WINDOW),
        .CNT_W      (32),
        .RELOCK_THR (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .i_valid     (i_valid),
        .i_ref_bit   (i_ref_bit),
        .i_rx_bit    (i_rx_bit),
        .i_clear     (i_clear),
        .o_locked    (o_locked),
        .o_delay     (o_delay),
        .o_bit_count (o_bit_count),
        .o_err_count (o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One qualified strobe; rx is the reference from 'lat' strobes ago.
    task automatic send(input bit flip);
        logic b;
        @(negedge clk);
        rst     = 1'b0;
        i_clear = 1'b0;
        enable  = 1'b1;
        i_valid = 1'b1;
        b       = r_prbs[8];
        r_prbs  = {r_prbs[7:0], r_prbs[8] ^ r_prbs[4]};
        for (int k = 63; k > 0; k--) tx_hist[k] = tx_hist[k-1];
        tx_hist[0] = b;
        i_ref_bit  = b;
        i_rx_bit   = tx_hist[lat] ^ flip;
    endtask

    task automatic send_n(input int n, input int flip_period);
        for (int i = 0; i < n; i++) begin
            send(flip_period > 0 && (i % flip_period) == flip_period - 1);
        end
    endtask

    // Ends the strobe train; outputs then reflect every strobe sent.
    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic gap_cycle();
        int p;
        @(negedge clk);
        p         = $urandom_range(0, 2);
        enable    = (p == 1);
        i_valid   = (p == 0);
        i_ref_bit = 1'($urandom_range(0, 1));
        i_rx_bit  = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        enable  = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        r_prbs = 9'h1FF;
        for (int k = 0; k < 64; k++) tx_hist[k] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", o_locked); end
        n_cmp++; if (o_delay !== 6'd0) begin n_fail++; $display("FAIL reset_delay: got %0d want 0", o_delay); end
        n_cmp++; if (o_bit_count !== 32'd0) begin n_fail++; $display("FAIL reset_bits: got %0d want 0", o_bit_count); end
        n_cmp++; if (o_err_count !== 32'd0) begin n_fail++; $display("FAIL reset_errs: got %0d want 0", o_err_count); end
    endtask

    task automatic test_zero_latency();
        lat = 0;
        send_n(c_SEARCH - 1, 0);
        idle();
        n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL zl_early_lock: got %0b want 0", o_locked); end
        send_n(1, 0);
        idle();
        n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL zl_locked: got %0b want 1", o_locked); end
        n_cmp++; if (o_delay !== 6'd0) begin n_fail++; $display("FAIL zl_delay: got %0d want 0", o_delay); end
        n_cmp++; if (o_bit_count !== 32'd0) begin n_fail++; $display("FAIL zl_bits_at_lock: got %0d want 0", o_bit_count); end
        send_n(1000, 0);
        idle();
        n_cmp++; if (o_bit_count !== 32'd1000) begin n_fail++; $display("FAIL zl_bits: got %0d want 1000", o_bit_count); end
        n_cmp++; if (o_err_count !== 32'd0) begin n_fail++; $display("FAIL zl_errs: got %0d want 0", o_err_count); end
    endtask

    task automatic test_latency37();
        do_reset();
        lat = 37;
        send_n(c_SEARCH, 0);
        idle();
        n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL l37_locked: got %0b want 1", o_locked); end
        n_cmp++; if (o_delay !== 6'd37) begin n_fail++; $display("FAIL l37_delay: got %0d want 37", o_delay); end
        send_n(500, 0);
        idle();
        n_cmp++; if (o_bit_count !== 32'd500) begin n_fail++; $display("FAIL l37_bits: got %0d want 500", o_bit_count); end
        n_cmp++; if (o_err_count !== 32'd0) begin n_fail++; $display("FAIL l37_errs: got %0d want 0", o_err_count); end
    endtask

    // Continues from the 37-symbol lock: 500 clean bits already counted.
    task automatic test_error_inject();
        send_n(10000, 100);
        idle();
        n_cmp++; if (o_bit_count !== 32'd10500) begin n_fail++; $display("FAIL inj_bits: got %0d want 10500", o_bit_count); end
        n_cmp++; if (o_err_count !== 32'd100) begin n_fail++; $display("FAIL inj_errs: got %0d want 100", o_err_count); end
        n_cmp++; if (o_delay !== 6'd37) begin n_fail++; $display("FAIL inj_delay: got %0d want 37", o_delay); end
    endtask

    task automatic test_gapped();
        do_reset();
        lat = 37;
        for (int i = 0; i < c_SEARCH + 1000; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) gap_cycle();
            send(i >= c_SEARCH && ((i - c_SEARCH) % 50) == 49);
        end
        gap_cycle();
        idle();
        n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL gap_locked: got %0b want 1", o_locked); end
        n_cmp++; if (o_delay !== 6'd37) begin n_fail++; $display("FAIL gap_delay: got %0d want 37", o_delay); end
        n_cmp++; if (o_bit_count !== 32'd1000) begin n_fail++; $display("FAIL gap_bits: got %0d want 1000", o_bit_count); end
        n_cmp++; if (o_err_count !== 32'd20) begin n_fail++; $display("FAIL gap_errs: got %0d want 20", o_err_count); end
    endtask

    task automatic test_reset_mid_search();
        do_reset();
        lat = 0;
        send_n(1999, 0);
        idle();
        // 1999 strobes complete 31 windows of 63.
        n_cmp++; if (o_delay !== 6'd31) begin n_fail++; $display("FAIL mid_sweep_delay: got %0d want 31", o_delay); end
        @(negedge clk);
        rst       = 1'b1;
        enable    = 1'b1;
        i_valid   = 1'b1;
        i_ref_bit = 1'b1;
        i_rx_bit  = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        n_cmp++; if (o_delay !== 6'd0) begin n_fail++; $display("FAIL mid_rst_delay: got %0d want 0", o_delay); end
        n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL mid_rst_locked: got %0b want 0", o_locked); end
        n_cmp++; if (o_bit_count !== 32'd0 || o_err_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", o_bit_count, o_err_count); end
        r_prbs = 9'h1FF;
        for (int k = 0; k < 64; k++) tx_hist[k] = 1'b0;
        send_n(c_SEARCH - 1, 0);
        idle();
        n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL mid_early_lock: got %0b want 0", o_locked); end
        send_n(1, 0);
        idle();
        n_cmp++; if (o_locked !== 1'b1 || o_delay !== 6'd0) begin n_fail++; $display("FAIL mid_relock: got %0b/%0d want 1/0", o_locked, o_delay); end
    endtask

    // Clear coincident with a strobe: the strobe is dropped, history kept.
    task automatic test_clear();
        send_n(10, 0);
        idle();
        n_cmp++; if (o_bit_count !== 32'd10) begin n_fail++; $display("FAIL clr_pre_bits: got %0d want 10", o_bit_count); end
        @(negedge clk);
        i_clear   = 1'b1;
        enable    = 1'b1;
        i_valid   = 1'b1;
        i_ref_bit = 1'b1;
        i_rx_bit  = 1'b0;
        @(negedge clk);
        i_clear = 1'b0;
        i_valid = 1'b0;
        n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked: got %0b want 0", o_locked); end
        n_cmp++; if (o_bit_count !== 32'd0 || o_err_count !== 32'd0) begin n_fail++; $display("FAIL clr_counts: got %0d/%0d want 0/0", o_bit_count, o_err_count); end
        send_n(c_SEARCH, 0);
        idle();
        n_cmp++; if (o_locked !== 1'b1 || o_delay !== 6'd0) begin n_fail++; $display("FAIL clr_relock: got %0b/%0d want 1/0", o_locked, o_delay); end
    endtask

`ifdef BER_CHECKER_RELOCK_EN
    task automatic test_relock();
        send_n(62, 1);
        idle();
        n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL rl_pre_drop: got %0b want 1", o_locked); end
        send_n(1, 1);
        idle();
        n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL rl_drop: got %0b want 0", o_locked); end
        n_cmp++; if (o_bit_count !== 32'd63 || o_err_count !== 32'd63) begin n_fail++; $display("FAIL rl_held: got %0d/%0d want 63/63", o_bit_count, o_err_count); end
        send_n(c_SEARCH, 0);
        idle();
        n_cmp++; if (o_locked !== 1'b1 || o_delay !== 6'd0) begin n_fail++; $display("FAIL rl_relock: got %0b/%0d want 1/0", o_locked, o_delay); end
        n_cmp++; if (o_bit_count !== 32'd63 || o_err_count !== 32'd63) begin n_fail++; $display("FAIL rl_kept: got %0d/%0d want 63/63", o_bit_count, o_err_count); end
    endtask
`else
    task automatic test_lock_terminal();
        send_n(200, 1);
        idle();
        n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL term_locked: got %0b want 1", o_locked); end
        n_cmp++; if (o_err_count !== 32'd200 || o_bit_count !== 32'd200) begin n_fail++; $display("FAIL term_counts: got %0d/%0d want 200/200", o_err_count, o_bit_count); end
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        i_valid   = 1'b0;
        i_ref_bit = 1'b0;
        i_rx_bit  = 1'b0;
        i_clear   = 1'b0;
        lat       = 0;
        r_prbs    = 9'h1FF;
        for (int k = 0; k < 64; k++) tx_hist[k] = 1'b0;

        test_reset();
        test_zero_latency();
        test_latency37();
        test_error_inject();
        test_gapped();
        test_reset_mid_search();
        test_clear();
`ifdef BER_CHECKER_RELOCK_EN
        test_relock();
`else
        test_lock_terminal();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
